// File: rtl/multi_stage_sync.sv
// Configurable-depth CDC synchroniser with optional stability filter, change pulse and rejected-transition counter.
// Optional Gray-to-binary output port data_bin enabled by defining MULTI_STAGE_SYNC_GRAY_DECODE_EN.
module multi_stage_sync #(
    parameter int              WIDTH      = 4,
    parameter int              STAGES     = 2,
    parameter int              STABLE_CNT = 0,
    parameter int              REJ_W      = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}}
) (
    input  logic             two_clk,
    input  logic             two_rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] data_out,
    output logic             changed,
    output logic [REJ_W-1:0] rej_cnt
`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
    ,
    output logic [WIDTH-1:0] data_bin
`endif
);

    localparam int               CNT_W   = (STABLE_CNT > 0) ? $clog2(STABLE_CNT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
    localparam logic [REJ_W-1:0] REJ_MAX = {REJ_W{1'b1}};

`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] data_bin_r;
`endif

    logic [WIDTH-1:0] stage_r [STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] prev_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] data_out_r;
    logic             changed_r;
    logic [REJ_W-1:0] rej_cnt_r;
    logic             qualify_s;
    logic             rej_evt_s;

    assign sync_s   = stage_r[STAGES-1];
    assign data_out = data_out_r;
    assign changed  = changed_r;
    assign rej_cnt  = rej_cnt_r;
`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
    assign data_bin = data_bin_r;
`endif

    // Plain flop chain: no logic between stages so each bit resolves metastability independently.
    always_ff @(posedge two_clk or posedge two_rst) begin
        if (two_rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= RST_VAL;
            end
        end else begin
            stage_r[0] <= async_in;
            for (int k = 1; k < STAGES; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    // Stability counter, qualify decision and rejection detection.
    always_comb begin
        qualify_s = 1'b1;
        rej_evt_s = 1'b0;
        cnt_nxt_s = cnt_r;
        if (STABLE_CNT == 0) begin
            qualify_s = 1'b1;
            rej_evt_s = 1'b0;
        end else begin
            qualify_s = (sync_s == prev_r) && (cnt_r == CNT_MAX);
            // A candidate that never reached data_out is being abandoned.
            rej_evt_s = (sync_s != prev_r) && (prev_r != data_out_r);
        end
        if (sync_s != prev_r) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Filter state, published value, change pulse and saturating reject counter.
    always_ff @(posedge two_clk or posedge two_rst) begin
        if (two_rst) begin
            prev_r     <= RST_VAL;
            cnt_r      <= {CNT_W{1'b0}};
            data_out_r <= RST_VAL;
            changed_r  <= 1'b0;
            rej_cnt_r  <= {REJ_W{1'b0}};
`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
            data_bin_r <= gray2bin(RST_VAL);
`endif
        end else begin
            prev_r <= sync_s;
            cnt_r  <= cnt_nxt_s;
            if (qualify_s && (sync_s != data_out_r)) begin
                data_out_r <= sync_s;
                changed_r  <= 1'b1;
`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
                data_bin_r <= gray2bin(sync_s);
`endif
            end else begin
                data_out_r <= data_out_r;
                changed_r  <= 1'b0;
            end
            if (rej_evt_s && (rej_cnt_r != REJ_MAX)) begin
                rej_cnt_r <= rej_cnt_r + {{(REJ_W-1){1'b0}}, 1'b1};
            end else begin
                rej_cnt_r <= rej_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_multi_stage_sync.sv
// Bench for multi_stage_sync: four instances with different filter settings share one input bus.
module tb_multi_stage_sync;

    localparam int NI = 4;
    localparam int ST [NI] = '{2, 3, 2, 2};
    localparam int NN [NI] = '{0, 4, 3, 2};
    localparam int RW [NI] = '{8, 8, 2, 8};

    logic       two_clk = 1'b0;
    logic       two_rst = 1'b1;
    logic [3:0] async_in = 4'h0;

    logic [3:0] d_w   [NI];
    logic       chg_w [NI];
    logic [7:0] rej0_w, rej1_w, rej3_w;
    logic [1:0] rej2_w;
`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
    logic [3:0] bin_w [NI];
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 two_clk = ~two_clk;

    multi_stage_sync #(.WIDTH(4), .STAGES(2), .STABLE_CNT(0), .REJ_W(8), .RST_VAL(4'h0)) u0 (
        .two_clk(two_clk), .two_rst(two_rst), .async_in(async_in),
        .data_out(d_w[0]), .changed(chg_w[0]), .rej_cnt(rej0_w)
`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
        , .data_bin(bin_w[0])
`endif
    );
    multi_stage_sync #(.WIDTH(4), .STAGES(3), .STABLE_CNT(4), .REJ_W(8), .RST_VAL(4'h0)) u1 (
        .two_clk(two_clk), .two_rst(two_rst), .async_in(async_in),
        .data_out(d_w[1]), .changed(chg_w[1]), .rej_cnt(rej1_w)
`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
        , .data_bin(bin_w[1])
`endif
    );
    multi_stage_sync #(.WIDTH(4), .STAGES(2), .STABLE_CNT(3), .REJ_W(2), .RST_VAL(4'h0)) u2 (
        .two_clk(two_clk), .two_rst(two_rst), .async_in(async_in),
        .data_out(d_w[2]), .changed(chg_w[2]), .rej_cnt(rej2_w)
`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
        , .data_bin(bin_w[2])
`endif
    );
    multi_stage_sync #(.WIDTH(4), .STAGES(2), .STABLE_CNT(2), .REJ_W(8), .RST_VAL(4'h0)) u3 (
        .two_clk(two_clk), .two_rst(two_rst), .async_in(async_in),
        .data_out(d_w[3]), .changed(chg_w[3]), .rej_cnt(rej3_w)
`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
        , .data_bin(bin_w[3])
`endif
    );

    function automatic int rej_of(input int k);
        case (k)
            0:       return int'(rej0_w);
            1:       return int'(rej1_w);
            2:       return int'(rej2_w);
            default: return int'(rej3_w);
        endcase
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    // Reference model: the input history is a delay line; stability is a run length of the synchronised value.
    logic [3:0] hist [$];
    logic [3:0] m_sync [NI];
    logic [3:0] m_last [NI];
    logic [3:0] m_data [NI];
    logic [3:0] m_bin  [NI];
    logic       m_chg  [NI];
    int         m_run  [NI];
    int         m_rej  [NI];

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < 8; j++) hist.push_back(4'h0);
        for (int k = 0; k < NI; k++) begin
            m_sync[k] = 4'h0; m_last[k] = 4'h0; m_data[k] = 4'h0; m_bin[k] = 4'h0;
            m_chg[k] = 1'b0; m_run[k] = 2; m_rej[k] = 0;
        end
    endtask

    task automatic model_edge(input logic [3:0] a);
        logic [3:0] nxt;
        bit         qual;
        hist.push_back(a);
        void'(hist.pop_front());
        for (int k = 0; k < NI; k++) begin
            qual = (NN[k] == 0) || (m_run[k] >= NN[k] + 2);
            if (NN[k] > 0 && m_sync[k] != m_last[k] && m_last[k] != m_data[k]
                && m_rej[k] < (1 << RW[k]) - 1)
                m_rej[k]++;
            if (qual && m_sync[k] != m_data[k]) begin
                m_data[k] = m_sync[k];
                m_bin[k]  = g2b(m_sync[k]);
                m_chg[k]  = 1'b1;
            end else begin
                m_chg[k] = 1'b0;
            end
            nxt = hist[8 - ST[k]];
            m_last[k] = m_sync[k];
            m_sync[k] = nxt;
            if (nxt == m_last[k]) m_run[k] = (m_run[k] < 100) ? m_run[k] + 1 : m_run[k];
            else m_run[k] = 1;
        end
    endtask

    always @(posedge two_clk or posedge two_rst) begin
        if (two_rst) model_reset();
        else model_edge(async_in);
    end

    task automatic do_reset();
        @(negedge two_clk);
        two_rst  = 1'b1;
        async_in = 4'h0;
        @(negedge two_clk);
        @(negedge two_clk);
        two_rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge two_clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        async_in = 4'hF;
        repeat (10) tick();
        n_vec++;
        if (d_w[0] !== 4'hF) begin
            n_err++; $display("FAIL pre_reset_data got %h want %h", d_w[0], 4'hF);
        end
        @(negedge two_clk);
        #2 two_rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (d_w[k] !== 4'h0 || chg_w[k] !== 1'b0 || rej_of(k) != 0) begin
                n_err++;
                $display("FAIL async_reset inst %0d got d=%h c=%b r=%0d want 0/0/0",
                         k, d_w[k], chg_w[k], rej_of(k));
            end
        end
        async_in = 4'h0;
        @(negedge two_clk);
        two_rst = 1'b0;
    endtask

    task automatic test_bypass_latency();
        do_reset();
        async_in = 4'hA;
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_vec++;
            if (d_w[0] !== ((e >= 3) ? 4'hA : 4'h0) || chg_w[0] !== (e == 3) || rej0_w !== 8'd0) begin
                n_err++;
                $display("FAIL bypass_edge%0d got d=%h c=%b r=%0d", e, d_w[0], chg_w[0], rej0_w);
            end
        end
    endtask

    task automatic test_filter_latency();
        int pulses = 0;
        do_reset();
        async_in = 4'h5;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (chg_w[1] === 1'b1) pulses++;
            if (e == 8 || e == 9) begin
                n_vec++;
                if (d_w[1] !== ((e == 9) ? 4'h5 : 4'h0) || chg_w[1] !== (e == 9)) begin
                    n_err++;
                    $display("FAIL filter_edge%0d got d=%h c=%b", e, d_w[1], chg_w[1]);
                end
            end
        end
        n_vec++;
        if (pulses != 1) begin
            n_err++; $display("FAIL filter_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_glitch_reject();
        int p0 = 0, p1 = 0;
        do_reset();
        async_in = 4'h3;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (chg_w[0] === 1'b1) p0++;
            if (chg_w[1] === 1'b1) p1++;
            @(negedge two_clk);
            if (e == 2) async_in = 4'h0;
        end
        n_vec++;
        if (d_w[1] !== 4'h0 || p1 != 0 || rej1_w !== 8'd1) begin
            n_err++; $display("FAIL glitch_filter got d=%h pulses=%0d r=%0d want 0/0/1", d_w[1], p1, rej1_w);
        end
        n_vec++;
        if (p0 != 2 || rej0_w !== 8'd0) begin
            n_err++; $display("FAIL glitch_bypass got pulses=%0d r=%0d want 2/0", p0, rej0_w);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int g = 0; g < 5; g++) begin
            async_in = 4'h3;
            repeat (2) @(negedge two_clk);
            async_in = 4'h0;
            repeat (4) @(negedge two_clk);
        end
        repeat (10) tick();
        n_vec++;
        if (rej2_w !== 2'd3 || d_w[2] !== 4'h0) begin
            n_err++; $display("FAIL sat_rej got r=%0d d=%h want 3/0", rej2_w, d_w[2]);
        end
        n_vec++;
        if (rej1_w !== 8'd5) begin
            n_err++; $display("FAIL sat_wide got %0d want 5", rej1_w);
        end
        async_in = 4'h3;
        repeat (2) @(negedge two_clk);
        async_in = 4'h0;
        repeat (10) tick();
        n_vec++;
        if (rej2_w !== 2'd3) begin
            n_err++; $display("FAIL sat_hold got %0d want 3", rej2_w);
        end
    endtask

    task automatic test_gray_decode();
        logic [3:0] seq [5] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6};
        int pulses = 0;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            async_in = seq[s];
            for (int c = 0; c < 10; c++) begin
                tick();
                if (chg_w[3] === 1'b1) pulses++;
                @(negedge two_clk);
            end
            n_vec++;
            if (d_w[3] !== seq[s]) begin
                n_err++; $display("FAIL gray_data step %0d got %h want %h", s, d_w[3], seq[s]);
            end
`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
            n_vec++;
            if (bin_w[3] !== 4'(s)) begin
                n_err++; $display("FAIL gray_bin step %0d got %h want %h", s, bin_w[3], 4'(s));
            end
`endif
        end
        n_vec++;
        if (pulses != 4) begin
            n_err++; $display("FAIL gray_pulses got %0d want 4", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [3] = '{4'h1, 4'h2, 4'h3};
        do_reset();
        for (int e = 1; e <= 6; e++) begin
            if (e <= 3) async_in = vals[e-1];
            tick();
            if (e >= 3) begin
                n_vec++;
                if (chg_w[0] !== (e <= 5) || d_w[0] !== ((e <= 5) ? vals[e-3] : 4'h3)) begin
                    n_err++; $display("FAIL b2b_edge%0d got d=%h c=%b", e, d_w[0], chg_w[0]);
                end
            end
            @(negedge two_clk);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                async_in = 4'($urandom_range(0, 15));
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 12) : $urandom_range(1, 5);
            end
            hold--;
            tick();
            for (int k = 0; k < NI; k++) begin
                n_vec++;
                if (d_w[k] !== m_data[k] || chg_w[k] !== m_chg[k] || rej_of(k) != m_rej[k]) begin
                    n_err++;
                    $display("FAIL random cyc %0d inst %0d got d=%h c=%b r=%0d want d=%h c=%b r=%0d",
                             i, k, d_w[k], chg_w[k], rej_of(k), m_data[k], m_chg[k], m_rej[k]);
                end
`ifdef MULTI_STAGE_SYNC_GRAY_DECODE_EN
                n_vec++;
                if (bin_w[k] !== m_bin[k]) begin
                    n_err++; $display("FAIL random_bin cyc %0d inst %0d got %h want %h", i, k, bin_w[k], m_bin[k]);
                end
`endif
            end
            @(negedge two_clk);
        end
    endtask

    initial begin
        test_reset();
        test_bypass_latency();
        test_filter_latency();
        test_glitch_reject();
        test_saturation();
        test_gray_decode();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
